// File: rtl/ccff_chain_loader_if.sv
// Host configuration handshake and serial chain signals for ccff_chain_loader.
// slave is the loader's view; master is the host / chain side.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, cfg_data, cfg_valid, ccff_tail,
    output cfg_ready, ccff_head, shift_en, busy, done, error
  );

  modport master (
    output start, cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, ccff_head, shift_en, busy, done, error
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises host configuration words LSB-first into a CHAIN_LEN-bit flip-flop chain.
// Define CCFF_READBACK_EN to add a recirculating CRC-8 readback check (VERIFY/ERROR).
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 67,
  parameter int WORD_W    = 8
) (
  input logic               prog_clk,
  input logic               pReset,
  ccff_chain_loader_if.slave bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int SB_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [SB_W-1:0]  FULL_WORD = SB_W'(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
`ifdef CCFF_READBACK_EN
    S_VERIFY = 3'd2,
    S_ERROR  = 3'd4,
`endif
    S_DONE   = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [SB_W-1:0]   sbits_q, sbits_d;
  logic              done_q, done_d;
  logic              ready_c, shift_c, head_c;

`ifdef CCFF_READBACK_EN
  logic              error_q, error_d;
  logic [7:0]        crc_load_q, crc_load_d;
  logic [7:0]        crc_ver_q, crc_ver_d;

  // Bit-serial CRC-8, polynomial x^8 + x^2 + x + 1, MSB-first register.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`else
  logic unused_tail;
  assign unused_tail = bus.ccff_tail;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    sbits_d = sbits_q;
    done_d  = done_q;
    ready_c = 1'b0;
    shift_c = 1'b0;
    head_c  = 1'b0;
`ifdef CCFF_READBACK_EN
    error_d    = error_q;
    crc_load_d = crc_load_q;
    crc_ver_d  = crc_ver_q;
`endif
    case (state_q)
      S_LOAD: begin
        // Taking a new word while the last bit leaves keeps the stream bubble-free.
        ready_c = (sbits_q == '0) || ((sbits_q == SB_W'(1)) && (cnt_q < LAST_BIT));
        shift_c = (sbits_q != '0);
        head_c  = shift_c & sreg_q[0];
        if (shift_c) begin
          cnt_d   = cnt_q + CNT_W'(1);
          sreg_d  = sreg_q >> 1;
          sbits_d = sbits_q - SB_W'(1);
`ifdef CCFF_READBACK_EN
          crc_load_d = crc8_step(crc_load_q, sreg_q[0]);
`endif
        end
        if (ready_c && bus.cfg_valid) begin
          sreg_d  = bus.cfg_data;
          sbits_d = FULL_WORD;
        end
        if (shift_c && (cnt_q == LAST_BIT)) begin
          sbits_d = '0;
`ifdef CCFF_READBACK_EN
          cnt_d   = '0;
          state_d = S_VERIFY;
`else
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end
      end
`ifdef CCFF_READBACK_EN
      S_VERIFY: begin
        // Recirculate tail into head so the chain image survives the readback.
        shift_c   = 1'b1;
        head_c    = bus.ccff_tail;
        cnt_d     = cnt_q + CNT_W'(1);
        crc_ver_d = crc8_step(crc_ver_q, bus.ccff_tail);
        if (cnt_q == LAST_BIT) begin
          if (crc_ver_d == crc_load_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
`endif
      default: begin
        if (bus.start) begin
          cnt_d   = '0;
          sbits_d = '0;
          done_d  = 1'b0;
          state_d = S_LOAD;
`ifdef CCFF_READBACK_EN
          error_d    = 1'b0;
          crc_load_d = 8'h00;
          crc_ver_d  = 8'h00;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      sbits_q <= '0;
      done_q  <= 1'b0;
`ifdef CCFF_READBACK_EN
      error_q    <= 1'b0;
      crc_load_q <= 8'h00;
      crc_ver_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      sbits_q <= sbits_d;
      done_q  <= done_d;
`ifdef CCFF_READBACK_EN
      error_q    <= error_d;
      crc_load_q <= crc_load_d;
      crc_ver_q  <= crc_ver_d;
`endif
    end
  end

  // Gating with pReset stops a shift or handshake from landing on the reset edge.
  assign bus.cfg_ready = ready_c & pReset;
  assign bus.shift_en  = shift_c & pReset;
  assign bus.ccff_head = head_c & pReset;
  assign bus.done      = done_q;
`ifdef CCFF_READBACK_EN
  assign bus.busy  = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign bus.error = error_q;
`else
  assign bus.busy  = (state_q == S_LOAD);
  assign bus.error = 1'b0;
`endif

endmodule
